// File: rtl/branch_pkg.sv
// branch_pkg: shared types for the fetch PC generator and branch metadata pipe.
// The select encoding is shared with the two-bit predictor.
package branch_pkg;

  typedef enum logic [1:0] {
    PCSEL_IF_PLUS4     = 2'b00,
    PCSEL_EXMEM_PLUS4  = 2'b01,
    PCSEL_BTB          = 2'b10,
    PCSEL_EXMEM_TARGET = 2'b11
  } pcsel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        btb_hit;
    logic        prediction;
  } br_meta_t;

  localparam logic [31:0] PC_INC  = 32'd4;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    if (en && (v != CNT_MAX)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/br_meta_stage.sv
// br_meta_stage: one branch-metadata pipeline register.
// Flush beats hold; hold beats bubble.
module br_meta_stage
  import branch_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  logic     hold_i,
  input  logic     bubble_i,
  input  br_meta_t d_i,
  output br_meta_t q_o
);

  br_meta_t r_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_q <= '0;
    end else begin
      priority case (1'b1)
        flush_i:  r_q <= '0;
        hold_i:   r_q <= r_q;
        bubble_i: r_q <= '0;
        default:  r_q <= d_i;
      endcase
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/branch_fetch_pipe.sv
// branch_fetch_pipe: fetch PC register plus IF/ID, ID/EX, EX/MEM branch
// metadata, presented to the predictor as EXMEM_* commit signals.
module branch_fetch_pipe
  import branch_pkg::*;
#(
  parameter  int unsigned INDEX_WIDTH = 12,
  parameter  logic [31:0] RESET_PC    = 32'h0000_0000,
  localparam int unsigned TAG_W       = 32 - INDEX_WIDTH - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_i,
  input  logic [1:0]             IF_PCnext_sel_i,
  input  logic                   IF_flush_i,
  input  logic [31:0]            IF_btb_rd_target_i,
  input  logic                   IF_btb_hit_i,
  input  logic                   IF_prediction_i,
  input  logic                   EX_is_jmp_i,
  input  logic                   EX_br_taken_i,
  input  logic [31:0]            EX_br_target_i,
  output logic [31:0]            IF_pc_o,
  output logic [TAG_W-1:0]       IF_PC_tag_o,
  output logic [INDEX_WIDTH-1:0] IF_btb_rd_index_o,
  output logic [31:0]            EXMEM_pc_o,
  output logic [INDEX_WIDTH-1:0] EXMEM_btb_wr_index_o,
  output logic [TAG_W-1:0]       EXMEM_btb_wr_tag_o,
  output logic [31:0]            EXMEM_btb_wr_target_o,
  output logic                   EXMEM_btb_hit_o,
  output logic                   EXMEM_prediction_o,
  output logic                   EXMEM_br_decision_o,
  output logic                   EXMEM_is_jmp_o,
  output logic [31:0]            br_count_o,
  output logic [31:0]            mispredict_count_o
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_raw;
  logic [31:0] w_next_pc;
  pcsel_e      w_sel;

  br_meta_t    w_if_meta;
  br_meta_t    w_ifid;
  br_meta_t    w_idex;

  br_meta_t    r_mem;
  logic        r_mem_jmp;
  logic        r_mem_tk;
  logic [31:0] r_mem_tgt;

  logic [31:0] r_br_cnt;
  logic [31:0] r_mis_cnt;
  logic        w_commit;
  logic        w_mispredict;

  assign w_sel = pcsel_e'(IF_PCnext_sel_i);

  always_comb begin
    w_pc_raw = r_pc + PC_INC;
    unique case (w_sel)
      PCSEL_IF_PLUS4:     w_pc_raw = r_pc + PC_INC;
      PCSEL_EXMEM_PLUS4:  w_pc_raw = r_mem.pc + PC_INC;
      PCSEL_BTB:          w_pc_raw = IF_btb_rd_target_i;
      PCSEL_EXMEM_TARGET: w_pc_raw = r_mem_tgt;
      default:            w_pc_raw = r_pc + PC_INC;
    endcase
  end

  assign w_next_pc = word_align(w_pc_raw);

  // A flush redirects fetch even while a hazard stall is pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= word_align(RESET_PC);
    end else if (IF_flush_i || !stall_i) begin
      r_pc <= w_next_pc;
    end
  end

  always_comb begin
    w_if_meta            = '0;
    w_if_meta.valid      = 1'b1;
    w_if_meta.pc         = r_pc;
    w_if_meta.btb_hit    = IF_btb_hit_i;
    w_if_meta.prediction = IF_prediction_i;
  end

  br_meta_stage u_ifid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (IF_flush_i),
    .hold_i   (stall_i),
    .bubble_i (1'b0),
    .d_i      (w_if_meta),
    .q_o      (w_ifid)
  );

  br_meta_stage u_idex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (IF_flush_i),
    .hold_i   (stall_i),
    .bubble_i (1'b0),
    .d_i      (w_ifid),
    .q_o      (w_idex)
  );

  // EX/MEM never holds: a stall drains the branch in MEM and inserts a bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem     <= '0;
      r_mem_jmp <= 1'b0;
      r_mem_tk  <= 1'b0;
      r_mem_tgt <= '0;
    end else if (IF_flush_i || stall_i) begin
      r_mem     <= '0;
      r_mem_jmp <= 1'b0;
      r_mem_tk  <= 1'b0;
      r_mem_tgt <= '0;
    end else begin
      r_mem     <= w_idex;
      r_mem_jmp <= EX_is_jmp_i;
      r_mem_tk  <= EX_br_taken_i;
      r_mem_tgt <= EX_br_target_i;
    end
  end

  assign w_commit     = r_mem.valid & r_mem_jmp;
  assign w_mispredict = w_commit & (r_mem.prediction != r_mem_tk);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      r_br_cnt  <= sat_inc(r_br_cnt, w_commit);
      r_mis_cnt <= sat_inc(r_mis_cnt, w_mispredict);
    end
  end

  assign IF_pc_o           = r_pc;
  assign IF_PC_tag_o       = r_pc[31:INDEX_WIDTH+2];
  assign IF_btb_rd_index_o = r_pc[INDEX_WIDTH+1:2];

  assign EXMEM_pc_o            = r_mem.pc;
  assign EXMEM_btb_wr_index_o  = r_mem.pc[INDEX_WIDTH+1:2];
  assign EXMEM_btb_wr_tag_o    = r_mem.pc[31:INDEX_WIDTH+2];
  assign EXMEM_btb_wr_target_o = r_mem_tgt;
  assign EXMEM_btb_hit_o       = r_mem.btb_hit;
  assign EXMEM_prediction_o    = r_mem.prediction;
  assign EXMEM_is_jmp_o        = w_commit;
  assign EXMEM_br_decision_o   = r_mem.valid & r_mem_tk;

  assign br_count_o         = r_br_cnt;
  assign mispredict_count_o = r_mis_cnt;

  a_pc_aligned: assert property (
    @(posedge clk_i) disable iff (!rst_i) r_pc[1:0] == 2'b00
  );

  a_mis_implies_br: assert property (
    @(posedge clk_i) disable iff (!rst_i) w_mispredict |-> w_commit
  );

endmodule

// File: tb/tb_branch_fetch_pipe.sv
// tb_branch_fetch_pipe: directed stimulus, per-cycle compare against a
// behavioural fetch/commit model, plus hand-computed literal checkpoints.
module tb_branch_fetch_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic        flush = 1'b0;
  logic [31:0] btb_tgt = '0;
  logic        btb_hit = 1'b0;
  logic        pred = 1'b0;
  logic        ex_jmp = 1'b0;
  logic        ex_tk = 1'b0;
  logic [31:0] ex_tgt = '0;

  logic [31:0] if_pc;
  logic [17:0] if_tag;
  logic [11:0] if_idx;
  logic [31:0] mem_pc;
  logic [11:0] mem_idx;
  logic [17:0] mem_tag;
  logic [31:0] mem_tgt;
  logic        mem_hit;
  logic        mem_pred;
  logic        mem_dec;
  logic        mem_jmp;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  int n_chk = 0;
  int n_err = 0;

  branch_fetch_pipe #(
    .INDEX_WIDTH (12),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .stall_i               (stall),
    .IF_PCnext_sel_i       (sel),
    .IF_flush_i            (flush),
    .IF_btb_rd_target_i    (btb_tgt),
    .IF_btb_hit_i          (btb_hit),
    .IF_prediction_i       (pred),
    .EX_is_jmp_i           (ex_jmp),
    .EX_br_taken_i         (ex_tk),
    .EX_br_target_i        (ex_tgt),
    .IF_pc_o               (if_pc),
    .IF_PC_tag_o           (if_tag),
    .IF_btb_rd_index_o     (if_idx),
    .EXMEM_pc_o            (mem_pc),
    .EXMEM_btb_wr_index_o  (mem_idx),
    .EXMEM_btb_wr_tag_o    (mem_tag),
    .EXMEM_btb_wr_target_o (mem_tgt),
    .EXMEM_btb_hit_o       (mem_hit),
    .EXMEM_prediction_o    (mem_pred),
    .EXMEM_br_decision_o   (mem_dec),
    .EXMEM_is_jmp_o        (mem_jmp),
    .br_count_o            (br_cnt),
    .mispredict_count_o    (mis_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: slot 0 = IF/ID, 1 = ID/EX, 2 = MEM.
  localparam longint SAT = 64'h0000_0000_FFFF_FFFF;
  logic [31:0] m_pc;
  logic        m_v[3];
  logic [31:0] m_spc[3];
  logic        m_hit[3];
  logic        m_pred[3];
  logic        m_jmp;
  logic        m_tk;
  logic [31:0] m_tgt;
  longint      m_br;
  longint      m_mis;
  logic [31:0] m_nxt;

  task automatic kill(input int s);
    m_v[s] = 1'b0;
    m_spc[s] = '0;
    m_hit[s] = 1'b0;
    m_pred[s] = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = '0;
      for (int i = 0; i < 3; i++) kill(i);
      m_jmp = 1'b0;
      m_tk = 1'b0;
      m_tgt = '0;
      m_br = 0;
      m_mis = 0;
    end else begin
      case (sel)
        2'd0:    m_nxt = m_pc + 32'd4;
        2'd1:    m_nxt = m_spc[2] + 32'd4;
        2'd2:    m_nxt = btb_tgt;
        default: m_nxt = m_tgt;
      endcase
      m_nxt[1:0] = 2'b00;
      if (m_v[2] && m_jmp) begin
        if (m_br < SAT) m_br++;
        if (m_pred[2] != m_tk && m_mis < SAT) m_mis++;
      end
      if (flush) begin
        m_pc = m_nxt;
        for (int i = 0; i < 3; i++) kill(i);
        m_jmp = 1'b0; m_tk = 1'b0; m_tgt = '0;
      end else if (stall) begin
        kill(2);
        m_jmp = 1'b0; m_tk = 1'b0; m_tgt = '0;
      end else begin
        m_v[2] = m_v[1]; m_spc[2] = m_spc[1];
        m_hit[2] = m_hit[1]; m_pred[2] = m_pred[1];
        m_jmp = ex_jmp; m_tk = ex_tk; m_tgt = ex_tgt;
        m_v[1] = m_v[0]; m_spc[1] = m_spc[0];
        m_hit[1] = m_hit[0]; m_pred[1] = m_pred[0];
        m_v[0] = 1'b1; m_spc[0] = m_pc;
        m_hit[0] = btb_hit; m_pred[0] = pred;
        m_pc = m_nxt;
      end
    end
  end

  always @(negedge clk) begin
    chk("if_pc", if_pc, m_pc);
    chk("if_tag", 32'(if_tag), 32'(m_pc[31:14]));
    chk("if_idx", 32'(if_idx), 32'(m_pc[13:2]));
    chk("is_jmp", 32'(mem_jmp), 32'(m_v[2] & m_jmp));
    chk("decision", 32'(mem_dec), 32'(m_v[2] & m_tk));
    chk("br_cnt", br_cnt, m_br[31:0]);
    chk("mis_cnt", mis_cnt, m_mis[31:0]);
    if (m_v[2]) begin
      chk("mem_pc", mem_pc, m_spc[2]);
      chk("mem_idx", 32'(mem_idx), 32'(m_spc[2][13:2]));
      chk("mem_tag", 32'(mem_tag), 32'(m_spc[2][31:14]));
      chk("mem_tgt", mem_tgt, m_tgt);
      chk("mem_hit", 32'(mem_hit), 32'(m_hit[2]));
      chk("mem_pred", 32'(mem_pred), 32'(m_pred[2]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_mem_pc", mem_pc, 32'h0);
    chk("rst_br", br_cnt, 32'h0);
    chk("rst_mis", mis_cnt, 32'h0);

    // straight-line fetch out of reset
    rst = 1'b1; ex_jmp = 1'b1;
    tick(); chk("t1_pc4", if_pc, 32'h4); chk("t1_jmp0", 32'(mem_jmp), 0);
    tick(); chk("t1_pc8", if_pc, 32'h8); chk("t1_jmp0b", 32'(mem_jmp), 0);
    tick(); chk("t1_pcC", if_pc, 32'hC);
    chk("t1_mem_pc", mem_pc, 32'h0); chk("t1_jmp1", 32'(mem_jmp), 1);
    ex_jmp = 1'b0;
    tick(); chk("t1_br", br_cnt, 32'd1); chk("t1_mis", mis_cnt, 32'd0);

    // predicted-taken fetch at 0x40
    sel = 2'd2; btb_tgt = 32'h40;
    tick(); chk("t2_pc40", if_pc, 32'h40);
    btb_tgt = 32'h103; btb_hit = 1'b1; pred = 1'b1;
    tick(); chk("t2_pc100", if_pc, 32'h100);
    sel = 2'd0; btb_hit = 1'b0; pred = 1'b0;
    tick();
    ex_jmp = 1'b1; ex_tk = 1'b1; ex_tgt = 32'h100;
    tick();
    chk("t2_mem_pc", mem_pc, 32'h40); chk("t2_hit", 32'(mem_hit), 1);
    chk("t2_pred", 32'(mem_pred), 1); chk("t2_tgt", mem_tgt, 32'h100);
    ex_jmp = 1'b0; ex_tk = 1'b0;
    tick(); chk("t2_br", br_cnt, 32'd2); chk("t2_mis", mis_cnt, 32'd0);

    // mispredict recovery
    sel = 2'd2; btb_tgt = 32'h40;
    tick(); chk("t3_pc40", if_pc, 32'h40);
    sel = 2'd0;
    tick(); tick();
    ex_jmp = 1'b1; ex_tk = 1'b1; ex_tgt = 32'h200;
    tick();
    chk("t3_mem_pc", mem_pc, 32'h40); chk("t3_dec", 32'(mem_dec), 1);
    flush = 1'b1; sel = 2'd3; ex_jmp = 1'b0; ex_tk = 1'b0;
    tick();
    chk("t3_pc200", if_pc, 32'h200);
    chk("t3_br", br_cnt, 32'd3); chk("t3_mis", mis_cnt, 32'd1);
    flush = 1'b0; sel = 2'd0; ex_jmp = 1'b1;
    tick(); chk("t3_bub2", 32'(mem_jmp), 0);
    tick(); chk("t3_bub3", 32'(mem_jmp), 0);
    tick();
    chk("t3_first", mem_pc, 32'h200); chk("t3_jmp", 32'(mem_jmp), 1);
    chk("t3_pc20C", if_pc, 32'h20C);

    // stall, then stall with flush
    stall = 1'b1;
    tick(); chk("t4_hold1", if_pc, 32'h20C); chk("t4_bub1", 32'(mem_jmp), 0);
    chk("t4_br", br_cnt, 32'd4);
    tick(); chk("t4_hold2", if_pc, 32'h20C); chk("t4_bub2", 32'(mem_jmp), 0);
    flush = 1'b1;
    tick(); chk("t4_sf_pc", if_pc, 32'h210);
    flush = 1'b0; stall = 1'b0;
    tick(); chk("t4_v0", 32'(mem_jmp), 0);
    tick(); chk("t4_v1", 32'(mem_jmp), 0);
    tick(); chk("t4_mem", mem_pc, 32'h210);
    ex_jmp = 1'b0;
    tick(); chk("t4_br5", br_cnt, 32'd5);

    // PC wrap, then redirect through EXMEM_pc+4
    sel = 2'd2; btb_tgt = 32'hFFFF_FFFC;
    tick(); chk("t5_top", if_pc, 32'hFFFF_FFFC);
    chk("t5_tag", 32'(if_tag), 32'h3FFFF); chk("t5_idx", 32'(if_idx), 32'hFFF);
    sel = 2'd0;
    tick(); chk("t5_wrap", if_pc, 32'h0);
    tick(); tick(); chk("t5_mem", mem_pc, 32'hFFFF_FFFC);
    flush = 1'b1; sel = 2'd1;
    tick(); chk("t5_m4", if_pc, 32'h0);
    flush = 1'b0; sel = 2'd0;
    repeat (3) tick();

    // counter saturation
    #2;
    force dut.r_br_cnt = 32'hFFFF_FFFE;
    force dut.r_mis_cnt = 32'hFFFF_FFFE;
    m_br = 64'hFFFF_FFFE; m_mis = 64'hFFFF_FFFE;
    #1;
    release dut.r_br_cnt;
    release dut.r_mis_cnt;
    ex_jmp = 1'b1; ex_tk = 1'b1;
    tick(); chk("t6_pre", mis_cnt, 32'hFFFF_FFFE);
    tick(); chk("t6_one", mis_cnt, 32'hFFFF_FFFF);
    tick();
    ex_jmp = 1'b0; ex_tk = 1'b0;
    tick(); tick();
    chk("t6_br_sat", br_cnt, 32'hFFFF_FFFF);
    chk("t6_mis_sat", mis_cnt, 32'hFFFF_FFFF);

    // asynchronous reset mid-run
    ex_jmp = 1'b1; ex_tk = 1'b1; ex_tgt = 32'h1234;
    tick(); chk("t6_tgt", mem_tgt, 32'h1234);
    #2 rst = 1'b0;
    #1;
    chk("ar_if_pc", if_pc, 32'h0);
    chk("ar_mem_pc", mem_pc, 32'h0);
    chk("ar_tgt", mem_tgt, 32'h0);
    chk("ar_jmp", 32'(mem_jmp), 0);
    chk("ar_dec", 32'(mem_dec), 0);
    chk("ar_br", br_cnt, 32'h0);
    chk("ar_mis", mis_cnt, 32'h0);
    ex_jmp = 1'b0; ex_tk = 1'b0; ex_tgt = '0;
    tick(); tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("end_pc", if_pc, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
